// File: rtl/dram_wr_arbiter.sv
// dram_wr_arbiter: round-robin sharing of one DRAM write port between two
// stream receivers, forwarding only complete bursts (data words, then command).

// Single-clock FIFO with occupancy counter, drop flag and registered full.
module dram_wr_fifo #(
    parameter int W     = 36,
    parameter int DEPTH = 256
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [W-1:0]             wdata,
    input  logic                     push,
    input  logic                     pop,
    output logic [W-1:0]             rdata,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     drop
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] DEPTH_C = (AW+1)'(DEPTH);
    localparam logic [AW:0] ONE_C = (AW+1)'(1);

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   count_d;
    logic          accept;
    logic          take;

    // The full test uses occupancy before the edge, even if a pop coincides.
    assign accept = push && (count < DEPTH_C);
    assign take   = pop && (count != '0);
    assign drop   = push && !accept;
    assign rdata  = mem[rd_ptr];

    // Next occupancy; a simultaneous push and pop leaves it unchanged.
    always_comb begin
        count_d = count;
        if (accept && !take) begin
            count_d = count + ONE_C;
        end else if (!accept && take) begin
            count_d = count - ONE_C;
        end
    end

    // Storage array, written only on accepted pushes.
    always_ff @(posedge clk) begin
        if (accept) begin
            mem[wr_ptr] <= wdata;
        end
    end

    // Pointers wrap modulo depth; full is registered from next occupancy.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            full   <= 1'b0;
        end else begin
            if (accept) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (take) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            count <= count_d;
            full  <= (count_d == DEPTH_C);
        end
    end
endmodule

module dram_wr_arbiter #(
    parameter int DATA_DEPTH = 256,
    parameter int CMD_DEPTH  = 8
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [35:0] data_in0,
    input  logic        data_we0,
    input  logic [35:0] data_in1,
    input  logic        data_we1,
    input  logic [39:0] ctrl_in0,
    input  logic        ctrl_we0,
    input  logic [39:0] ctrl_in1,
    input  logic        ctrl_we1,
    output logic        data_full0,
    output logic        data_full1,
    output logic [35:0] out_data,
    output logic        out_data_we,
    input  logic        out_data_full,
    output logic [39:0] out_ctrl,
    output logic        out_ctrl_we,
    input  logic        out_ctrl_full,
    output logic [1:0]  ovf,
    output logic        grant
);
    localparam int DAW = $clog2(DATA_DEPTH);
    localparam int CAW = $clog2(CMD_DEPTH);

    typedef enum logic [1:0] {
        S_IDLE,
        S_DATA,
        S_CMD
    } state_t;

    state_t state_q;
    state_t state_d;

    logic [35:0]  d_in   [2];
    logic [35:0]  d_head [2];
    logic [DAW:0] d_cnt  [2];
    logic [39:0]  c_in   [2];
    logic [39:0]  c_head [2];
    logic [CAW:0] c_cnt  [2];
    logic [6:0]   need   [2];
    logic [1:0]   d_we;
    logic [1:0]   c_we;
    logic [1:0]   d_pop;
    logic [1:0]   c_pop;
    logic [1:0]   d_full;
    logic [1:0]   d_drop;
    logic [1:0]   c_drop;
    logic [1:0]   elig;

    logic         pick;
    logic         rr;
    logic [6:0]   remain;
    logic [39:0]  cmd_q;
    logic         take;
    logic         word_go;
    logic         ctrl_go;

    // Lengths above 64 move 64 words; the command itself is forwarded as-is.
    function automatic logic [6:0] clamp_len(input logic [7:0] l);
        return (l > 8'd64) ? 7'd64 : l[6:0];
    endfunction

    assign d_in[0] = data_in0;
    assign d_in[1] = data_in1;
    assign c_in[0] = ctrl_in0;
    assign c_in[1] = ctrl_in1;
    assign d_we    = {data_we1, data_we0};
    assign c_we    = {ctrl_we1, ctrl_we0};

    assign data_full0 = d_full[0];
    assign data_full1 = d_full[1];

    for (genvar g = 0; g < 2; g++) begin : g_req
        dram_wr_fifo #(
            .W     (36),
            .DEPTH (DATA_DEPTH)
        ) u_data (
            .clk   (clk),
            .rst_n (rst_n),
            .wdata (d_in[g]),
            .push  (d_we[g]),
            .pop   (d_pop[g]),
            .rdata (d_head[g]),
            .count (d_cnt[g]),
            .full  (d_full[g]),
            .drop  (d_drop[g])
        );

        logic c_full_unused;

        dram_wr_fifo #(
            .W     (40),
            .DEPTH (CMD_DEPTH)
        ) u_cmd (
            .clk   (clk),
            .rst_n (rst_n),
            .wdata (c_in[g]),
            .push  (c_we[g]),
            .pop   (c_pop[g]),
            .rdata (c_head[g]),
            .count (c_cnt[g]),
            .full  (c_full_unused),
            .drop  (c_drop[g])
        );

        // A burst is eligible only once all of its data words are queued.
        assign need[g] = clamp_len(c_head[g][39:32]);
        assign elig[g] = (c_cnt[g] != '0) &&
                         (d_cnt[g] >= (DAW+1)'(need[g]));
    end

    // With both eligible the RR pointer decides, otherwise the lone one.
    assign pick = (elig[0] && elig[1]) ? rr : elig[1];

    // Scheduler state register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state and FIFO pops; len=0 commands are popped and dropped in IDLE.
    always_comb begin
        state_d = state_q;
        c_pop   = '0;
        d_pop   = '0;
        take    = 1'b0;
        word_go = 1'b0;
        ctrl_go = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (|elig) begin
                    c_pop[pick] = 1'b1;
                    if (need[pick] != 7'd0) begin
                        take    = 1'b1;
                        state_d = S_DATA;
                    end
                end
            end
            S_DATA: begin
                if (!out_data_full) begin
                    d_pop[grant] = 1'b1;
                    word_go      = 1'b1;
                    if (remain == 7'd1) begin
                        state_d = S_CMD;
                    end
                end
            end
            S_CMD: begin
                if (!out_ctrl_full) begin
                    ctrl_go = 1'b1;
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Burst context latched at selection; RR flips once the command goes out.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            grant  <= 1'b0;
            rr     <= 1'b0;
            remain <= '0;
            cmd_q  <= '0;
        end else begin
            if (take) begin
                grant  <= pick;
                remain <= need[pick];
                cmd_q  <= c_head[pick];
            end else if (word_go) begin
                remain <= remain - 7'd1;
            end
            if (ctrl_go) begin
                rr <= ~grant;
            end
        end
    end

    // Registered outputs toward the DRAM writer and sticky overflow flags.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out_data    <= '0;
            out_data_we <= 1'b0;
            out_ctrl    <= '0;
            out_ctrl_we <= 1'b0;
            ovf         <= '0;
        end else begin
            out_data_we <= word_go;
            out_ctrl_we <= ctrl_go;
            ovf         <= ovf | d_drop | c_drop;
            if (word_go) begin
                out_data <= d_head[grant];
            end
            if (ctrl_go) begin
                out_ctrl <= cmd_q;
            end
        end
    end
endmodule
